// File: rtl/mem_access_unit_pkg.sv
// Shared funct3 codes, FSM state encoding and IO address constants for the memory access unit.
// Pure definitions; no timing or flow-control content.
package mem_access_unit_pkg;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  localparam logic [31:0] IO_ADDR_0 = 32'h0003_0000;
  localparam logic [31:0] IO_ADDR_1 = 32'h0003_0004;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_STORE = 2'd2,
    ST_DRAIN = 2'd3
  } mau_state_t;

  // Access size encoded as bytes minus one.
  function automatic logic [2:0] f3_to_len(input logic [2:0] f3);
    case (f3[1:0])
      2'd0:    f3_to_len = 3'd0;
      2'd1:    f3_to_len = 3'd1;
      default: f3_to_len = 3'd3;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Combinational sign/zero extension of raw load data by RV32I funct3; zero latency, no flow control.
module load_extend
  import mem_access_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_raw,
  output logic [XLEN-1:0] o_ext
);

  always_comb begin
    o_ext = i_raw;
    case (i_funct3)
      F3_LB:   o_ext = {{(XLEN-8){i_raw[7]}}, i_raw[7:0]};
      F3_LH:   o_ext = {{(XLEN-16){i_raw[15]}}, i_raw[15:0]};
      F3_LBU:  o_ext = {{(XLEN-8){1'b0}}, i_raw[7:0]};
      F3_LHU:  o_ext = {{(XLEN-16){1'b0}}, i_raw[15:0]};
      default: o_ext = i_raw;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// One-outstanding load/store initiator toward memctrl; result one cycle after the done pulse.
// ex_ready only in IDLE; rdy_in low freezes all state, requests hold until done.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int XLEN      = 32,
  parameter int REG_IDX_W = 5
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 ex_valid,
  input  logic                 ex_is_store,
  input  logic [2:0]           ex_funct3,
  input  logic [ADDR_W-1:0]    ex_addr,
  input  logic [XLEN-1:0]      ex_wdata,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 flush,
  output logic                 ex_ready,
  output logic                 read_mem,
  output logic                 write_mem,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [XLEN-1:0]      mem_data_to_write,
  output logic [2:0]           data_len,
  input  logic                 mem_load_done,
  input  logic [XLEN-1:0]      mem_ctrl_load_to_mem,
  output logic                 wb_valid,
  output logic [REG_IDX_W-1:0] wb_rd,
  output logic [XLEN-1:0]      wb_data,
  output logic                 store_done
);

  mau_state_t           r_state;
  mau_state_t           w_state_nxt;
  logic                 w_accept;
  logic                 w_wb_fire;
  logic                 w_st_fire;
  logic [ADDR_W-1:0]    r_addr;
  logic [XLEN-1:0]      r_wdata;
  logic [2:0]           r_funct3;
  logic [REG_IDX_W-1:0] r_rd;
  logic                 r_wb_valid;
  logic [REG_IDX_W-1:0] r_wb_rd;
  logic [XLEN-1:0]      r_wb_data;
  logic                 r_store_done;
  logic [XLEN-1:0]      w_wmasked;
  logic [XLEN-1:0]      w_ext;

  always_comb begin
    case (ex_funct3[1:0])
      2'd0:    w_wmasked = {{(XLEN-8){1'b0}}, ex_wdata[7:0]};
      2'd1:    w_wmasked = {{(XLEN-16){1'b0}}, ex_wdata[15:0]};
      default: w_wmasked = ex_wdata;
    endcase
  end

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .i_funct3 (r_funct3),
    .i_raw    (mem_ctrl_load_to_mem),
    .o_ext    (w_ext)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_wb_fire   = 1'b0;
    w_st_fire   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (ex_valid && !flush) begin
          w_accept    = 1'b1;
          w_state_nxt = ex_is_store ? ST_STORE : ST_LOAD;
        end
      end
      ST_LOAD: begin
        // A flush alongside done discards the result; otherwise the access drains.
        if (mem_load_done) begin
          w_state_nxt = ST_IDLE;
          w_wb_fire   = !flush;
        end else if (flush) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_STORE: begin
        if (mem_load_done) begin
          w_state_nxt = ST_IDLE;
          w_st_fire   = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (mem_load_done) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)      r_state <= ST_IDLE;
    else if (rdy_in) r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_addr       <= '0;
      r_wdata      <= '0;
      r_funct3     <= '0;
      r_rd         <= '0;
      r_wb_valid   <= 1'b0;
      r_wb_rd      <= '0;
      r_wb_data    <= '0;
      r_store_done <= 1'b0;
    end else if (rdy_in) begin
      if (w_accept) begin
        r_addr   <= ex_addr;
        r_wdata  <= w_wmasked;
        r_funct3 <= ex_funct3;
        r_rd     <= ex_rd;
      end
      r_wb_valid   <= w_wb_fire;
      r_store_done <= w_st_fire;
      if (w_wb_fire) begin
        r_wb_rd   <= r_rd;
        r_wb_data <= w_ext;
      end
    end
  end

  // Request drops in the done cycle so memctrl never sees it as a new access.
  assign read_mem          = ((r_state == ST_LOAD) || (r_state == ST_DRAIN)) && !mem_load_done;
  assign write_mem         = (r_state == ST_STORE) && !mem_load_done;
  assign ex_ready          = (r_state == ST_IDLE);
  assign mem_addr          = r_addr;
  assign mem_data_to_write = r_wdata;
  assign data_len          = f3_to_len(r_funct3);
  assign wb_valid          = r_wb_valid;
  assign wb_rd             = r_wb_rd;
  assign wb_data           = r_wb_data;
  assign store_done        = r_store_done;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a hand-driven memctrl model.
module tb_mem_access_unit;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        ex_valid;
  logic        ex_is_store;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr;
  logic [31:0] ex_wdata;
  logic [4:0]  ex_rd;
  logic        flush;
  logic        ex_ready;
  logic        read_mem;
  logic        write_mem;
  logic [31:0] mem_addr;
  logic [31:0] mem_data_to_write;
  logic [2:0]  data_len;
  logic        mem_load_done;
  logic [31:0] mem_ctrl_load_to_mem;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        store_done;

  int tests  = 0;
  int errors = 0;

  // observations collected by serve()
  int          req_cnt, wb_cnt, sd_cnt, bad_hold;
  logic [31:0] wb_data_obs;
  logic [4:0]  wb_rd_obs;
  logic        ready_at_done, ready_after;

  mem_access_unit dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .ex_valid(ex_valid), .ex_is_store(ex_is_store), .ex_funct3(ex_funct3),
    .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd(ex_rd), .flush(flush),
    .ex_ready(ex_ready), .read_mem(read_mem), .write_mem(write_mem),
    .mem_addr(mem_addr), .mem_data_to_write(mem_data_to_write), .data_len(data_len),
    .mem_load_done(mem_load_done), .mem_ctrl_load_to_mem(mem_ctrl_load_to_mem),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .store_done(store_done)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic sample();
    if (wb_valid) begin
      wb_cnt++;
      wb_data_obs = wb_data;
      wb_rd_obs   = wb_rd;
    end
    if (store_done) sd_cnt++;
  endtask

  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [4:0] rd);
    ex_valid = 1'b1; ex_is_store = st; ex_funct3 = f3;
    ex_addr = a; ex_wdata = wd; ex_rd = rd;
    tick();
    ex_valid = 1'b0;
  endtask

  // Memctrl model: done on cycle index lat after acceptance; optional flush on cycle flush_at.
  task automatic serve(input int lat, input logic [31:0] rdata, input int flush_at,
                       input logic [31:0] exp_addr, input logic [2:0] exp_len,
                       input logic [31:0] exp_wd);
    req_cnt = 0; wb_cnt = 0; sd_cnt = 0; bad_hold = 0;
    wb_data_obs = '0; wb_rd_obs = '0; ready_at_done = 1'bx;
    for (int c = 0; c <= lat; c++) begin
      flush                = (c == flush_at);
      mem_load_done        = (c == lat);
      mem_ctrl_load_to_mem = (c == lat) ? rdata : 32'h0;
      #1;
      sample();
      if (read_mem || write_mem) begin
        req_cnt++;
        if (mem_addr !== exp_addr || data_len !== exp_len || mem_data_to_write !== exp_wd)
          bad_hold++;
      end
      if (c == lat) ready_at_done = ex_ready;
      tick();
    end
    mem_load_done = 1'b0; flush = 1'b0; mem_ctrl_load_to_mem = '0;
    #1;
    sample();
    ready_after = ex_ready;
    tick();
    sample();
    if (read_mem || write_mem) req_cnt++;
    tick();
  endtask

  task automatic test_reset();
    rst_in = 1'b1; rdy_in = 1'b1; ex_valid = 0; ex_is_store = 0; ex_funct3 = 0;
    ex_addr = 0; ex_wdata = 0; ex_rd = 0; flush = 0; mem_load_done = 0;
    mem_ctrl_load_to_mem = 0;
    tick(); tick();
    tests++;
    if ({read_mem, write_mem, wb_valid, store_done, ex_ready} !== 5'b00001) begin
      errors++;
      $display("FAIL reset_ctrl got %b exp 00001", {read_mem, write_mem, wb_valid, store_done, ex_ready});
    end
    tests++;
    if (mem_addr !== 0 || mem_data_to_write !== 0 || data_len !== 0 || wb_rd !== 0 || wb_data !== 0) begin
      errors++;
      $display("FAIL reset_data got addr=%h wd=%h len=%0d rd=%0d wbd=%h exp all 0",
               mem_addr, mem_data_to_write, data_len, wb_rd, wb_data);
    end
    rst_in = 1'b0;
    tick();
  endtask

  task automatic test_lb();
    issue(1'b0, 3'd0, 32'h100, 32'h0, 5'd7);
    tests++;
    if (read_mem !== 1'b1 || ex_ready !== 1'b0) begin
      errors++;
      $display("FAIL lb_req_visible got rd=%b rdy=%b exp 1 0", read_mem, ex_ready);
    end
    serve(3, 32'h0000_00F0, -1, 32'h100, 3'd0, 32'h0);
    tests++;
    if (req_cnt != 3) begin errors++; $display("FAIL lb_req_cycles got %0d exp 3", req_cnt); end
    tests++;
    if (bad_hold != 0) begin errors++; $display("FAIL lb_hold got %0d bad exp 0", bad_hold); end
    tests++;
    if (wb_cnt != 1 || wb_data_obs !== 32'hFFFF_FFF0 || wb_rd_obs !== 5'd7) begin
      errors++;
      $display("FAIL lb_wb got cnt=%0d data=%h rd=%0d exp 1 fffffff0 7", wb_cnt, wb_data_obs, wb_rd_obs);
    end
    tests++;
    if (ready_at_done !== 1'b0 || ready_after !== 1'b1) begin
      errors++;
      $display("FAIL lb_ready got done=%b after=%b exp 0 1", ready_at_done, ready_after);
    end
  endtask

  task automatic test_lh_lhu();
    issue(1'b0, 3'd5, 32'h204, 32'h0, 5'd3);
    serve(2, 32'h0000_ABCD, -1, 32'h204, 3'd1, 32'h0);
    tests++;
    if (wb_cnt != 1 || wb_data_obs !== 32'h0000_ABCD || bad_hold != 0) begin
      errors++;
      $display("FAIL lhu got cnt=%0d data=%h bad=%0d exp 1 0000abcd 0", wb_cnt, wb_data_obs, bad_hold);
    end
    issue(1'b0, 3'd1, 32'h204, 32'h0, 5'd4);
    serve(2, 32'h0000_ABCD, -1, 32'h204, 3'd1, 32'h0);
    tests++;
    if (wb_cnt != 1 || wb_data_obs !== 32'hFFFF_ABCD || wb_rd_obs !== 5'd4 || bad_hold != 0) begin
      errors++;
      $display("FAIL lh got cnt=%0d data=%h rd=%0d bad=%0d exp 1 ffffabcd 4 0",
               wb_cnt, wb_data_obs, wb_rd_obs, bad_hold);
    end
    issue(1'b0, 3'd4, 32'h208, 32'h0, 5'd5);
    serve(1, 32'h1234_5680, -1, 32'h208, 3'd0, 32'h0);
    tests++;
    if (wb_data_obs !== 32'h0000_0080) begin
      errors++; $display("FAIL lbu got %h exp 00000080", wb_data_obs);
    end
  endtask

  task automatic test_store();
    issue(1'b1, 3'd2, 32'h0003_0000, 32'hDEAD_BEEF, 5'd9);
    tests++;
    if (write_mem !== 1'b1 || read_mem !== 1'b0) begin
      errors++; $display("FAIL sw_req got wr=%b rd=%b exp 1 0", write_mem, read_mem);
    end
    serve(6, 32'h0, -1, 32'h0003_0000, 3'd3, 32'hDEAD_BEEF);
    tests++;
    if (req_cnt != 6 || bad_hold != 0) begin
      errors++; $display("FAIL sw_hold got cycles=%0d bad=%0d exp 6 0", req_cnt, bad_hold);
    end
    tests++;
    if (sd_cnt != 1 || wb_cnt != 0) begin
      errors++; $display("FAIL sw_done got store_done=%0d wb=%0d exp 1 0", sd_cnt, wb_cnt);
    end
    issue(1'b1, 3'd0, 32'h0003_0004, 32'h1234_5678, 5'd0);
    serve(2, 32'h0, 0, 32'h0003_0004, 3'd0, 32'h0000_0078);
    tests++;
    if (req_cnt != 2 || bad_hold != 0 || sd_cnt != 1) begin
      errors++;
      $display("FAIL sb_flush_ignored got cycles=%0d bad=%0d sd=%0d exp 2 0 1", req_cnt, bad_hold, sd_cnt);
    end
  endtask

  task automatic test_flush();
    issue(1'b0, 3'd2, 32'h300, 32'h0, 5'd11);
    serve(5, 32'hCAFE_F00D, 2, 32'h300, 3'd3, 32'h0);
    tests++;
    if (req_cnt != 5 || wb_cnt != 0 || ready_after !== 1'b1) begin
      errors++;
      $display("FAIL flush_load got cycles=%0d wb=%0d ready=%b exp 5 0 1", req_cnt, wb_cnt, ready_after);
    end
    issue(1'b0, 3'd2, 32'h304, 32'h0, 5'd12);
    serve(2, 32'h5555_5555, 2, 32'h304, 3'd3, 32'h0);
    tests++;
    if (wb_cnt != 0 || ready_after !== 1'b1) begin
      errors++; $display("FAIL flush_with_done got wb=%0d ready=%b exp 0 1", wb_cnt, ready_after);
    end
    ex_valid = 1'b1; flush = 1'b1; ex_is_store = 1'b0; ex_addr = 32'h400;
    tick();
    ex_valid = 1'b0; flush = 1'b0;
    #1;
    tests++;
    if (ex_ready !== 1'b1 || read_mem !== 1'b0) begin
      errors++; $display("FAIL flush_idle got ready=%b rd=%b exp 1 0", ex_ready, read_mem);
    end
    tick();
  endtask

  task automatic test_rdy_stall();
    int stall_req;
    issue(1'b0, 3'd1, 32'h500, 32'h0, 5'd21);
    stall_req = 0;
    rdy_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (read_mem) stall_req++;
      tick();
    end
    rdy_in = 1'b1;
    tests++;
    if (stall_req != 4) begin errors++; $display("FAIL stall_req got %0d exp 4", stall_req); end
    serve(2, 32'h0000_8001, -1, 32'h500, 3'd1, 32'h0);
    tests++;
    if (wb_cnt != 1 || wb_data_obs !== 32'hFFFF_8001 || wb_rd_obs !== 5'd21 || req_cnt != 2) begin
      errors++;
      $display("FAIL stall_wb got cnt=%0d data=%h rd=%0d req=%0d exp 1 ffff8001 21 2",
               wb_cnt, wb_data_obs, wb_rd_obs, req_cnt);
    end
  endtask

  task automatic test_async_reset();
    issue(1'b1, 3'd2, 32'h0003_0000, 32'h0BAD_F00D, 5'd0);
    tests++;
    if (write_mem !== 1'b1) begin errors++; $display("FAIL areset_pre got wr=%b exp 1", write_mem); end
    #3;
    rst_in = 1'b1;
    #1;
    tests++;
    if (read_mem !== 1'b0 || write_mem !== 1'b0 || ex_ready !== 1'b1 || mem_addr !== 32'h0) begin
      errors++;
      $display("FAIL areset got rd=%b wr=%b ready=%b addr=%h exp 0 0 1 0", read_mem, write_mem, ex_ready, mem_addr);
    end
    tick();
    rst_in = 1'b0;
    tick();
    tests++;
    if (ex_ready !== 1'b1 || store_done !== 1'b0) begin
      errors++; $display("FAIL areset_after got ready=%b sd=%b exp 1 0", ex_ready, store_done);
    end
  endtask

  initial begin
    test_reset();
    test_lb();
    test_lh_lhu();
    test_store();
    test_flush();
    test_rdy_stall();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
